aes_shiftrows: RTL and testbench

// - AES ShiftRows stage for a 128-bit state, registered with a single pipeline stage.
// - Sits in the AES round datapath between SubBytes and MixColumns (final round: SubBytes -> AddRoundKey).
// - A valid flag travels alongside the data. There is no backpressure.

---
 rtl/aes_shiftrows.sv | 84 ++++++++
 tb/tb_aes_shiftrows.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shiftrows.sv
// ---------------------------------------------------------------------------
// aes_shiftrows
//   AES ShiftRows stage for one 128-bit state, with a single pipeline register.
//   It sits between SubBytes and MixColumns in the round datapath. A valid flag
//   travels with the data. There is no backpressure.
//
//   Byte b0 is i_block[127:120] and b15 is i_block[7:0]. The state is
//   column-major, so byte 4c+r is column c, row r. In the forward transform,
//   row r rotates left by r.
//
// Ports
//   clk      in   1    rising-edge clock
//   rst      in   1    synchronous, active-high reset (takes priority over i_valid)
//   i_valid  in   1    i_block carries a valid state this cycle
//   i_block  in   128  input state
//   i_inv    in   1    present only with SHIFTROWS_INV_EN; 1 selects InvShiftRows
//   o_valid  out  1    registered copy of i_valid
//   o_block  out  128  registered shifted state; holds its value while i_valid=0
//
// Configuration macro: SHIFTROWS_INV_EN
//   When defined, the i_inv port exists and InvShiftRows is available.
//   When undefined, the block performs the forward transform only.
// ---------------------------------------------------------------------------
module aes_shiftrows (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [127:0] i_block,
`ifdef SHIFTROWS_INV_EN
  input  logic         i_inv,
`endif
  output logic         o_valid,
  output logic [127:0] o_block
);

  logic [127:0] fwd_block;
`ifdef SHIFTROWS_INV_EN
  logic [127:0] inv_block;
`endif
  logic [127:0] shifted_next;
  logic         valid_reg;
  logic [127:0] block_reg;

  // Pure byte permutation. Output byte gi (column c, row r) comes from input
  // column (c+r) mod 4 in the forward direction. In the inverse direction it
  // comes from input column (c-r) mod 4. Row r is unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int COL     = gi / 4;
      localparam int ROW     = gi % 4;
      localparam int FWD_SRC = 4 * ((COL + ROW) % 4) + ROW;
      assign fwd_block[127 - 8*gi -: 8] = i_block[127 - 8*FWD_SRC -: 8];
`ifdef SHIFTROWS_INV_EN
      localparam int INV_SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
      assign inv_block[127 - 8*gi -: 8] = i_block[127 - 8*INV_SRC -: 8];
`endif
    end
  endgenerate

`ifdef SHIFTROWS_INV_EN
  assign shifted_next = i_inv ? inv_block : fwd_block;
`else
  assign shifted_next = fwd_block;
`endif

  // o_valid follows i_valid every cycle.
  // The data register loads only when i_valid is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      block_reg <= 128'h0;
    end else begin
      valid_reg <= i_valid;
      if (i_valid) begin
        block_reg <= shifted_next;
      end
    end
  end

  assign o_valid = valid_reg;
  assign o_block = block_reg;

endmodule

// File: tb/tb_aes_shiftrows.sv
// ---------------------------------------------------------------------------
// tb_aes_shiftrows
//   Self-checking bench for aes_shiftrows. Each driven cycle pushes the
//   expected {o_valid, o_block} onto a queue. The entry is popped and compared
//   one edge later. Define SHIFTROWS_INV_EN to connect i_inv and run the
//   inverse tests.
// ---------------------------------------------------------------------------
module tb_aes_shiftrows;

  typedef struct packed {
    logic         v;
    logic [127:0] b;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic [127:0] i_block;
  logic         i_inv;
  logic         o_valid;
  logic [127:0] o_block;

  int           checks;
  int           errors;
  int           txn;
  exp_t         exp_q[$];
  logic [127:0] hold_model;

  aes_shiftrows dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_block (i_block),
`ifdef SHIFTROWS_INV_EN
    .i_inv   (i_inv),
`endif
    .o_valid (o_valid),
    .o_block (o_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference permutations, taken directly from the listed byte orders.
  function automatic logic [127:0] fwd_model(input logic [127:0] blk);
    logic [7:0] x[16];
    for (int i = 0; i < 16; i++) x[i] = blk[127 - 8*i -: 8];
    return {x[0], x[5], x[10], x[15], x[4], x[9], x[14], x[3],
            x[8], x[13], x[2], x[7], x[12], x[1], x[6], x[11]};
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] blk);
    logic [7:0] x[16];
    for (int i = 0; i < 16; i++) x[i] = blk[127 - 8*i -: 8];
    return {x[0], x[13], x[10], x[7], x[4], x[1], x[14], x[11],
            x[8], x[5], x[2], x[15], x[12], x[9], x[6], x[3]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one cycle with a given expected result, then advance past the edge.
  task automatic apply_exp(input logic v, input logic [127:0] blk,
                           input logic inv, input logic [127:0] exp_blk);
    exp_t e;
    i_valid = v;
    i_block = blk;
    i_inv   = inv;
    if (v) hold_model = exp_blk;
    e.v = v;
    e.b = hold_model;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, using the model to produce the expected result.
  task automatic apply(input logic v, input logic [127:0] blk, input logic inv);
    apply_exp(v, blk, inv, inv ? inv_model(blk) : fwd_model(blk));
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    i_valid = 1'b1;
    i_inv   = 1'b0;
    i_block = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_block !== 128'h0) begin
      errors++;
      $display("FAIL reset: got v=%b blk=%h, want v=0 blk=0", o_valid, o_block);
    end
    rst        = 1'b0;
    i_valid    = 1'b0;
    hold_model = 128'h0;
    exp_q.delete();
  endtask

  task automatic test_vectors();
    logic [127:0] vin[4];
    logic [127:0] vout[4];
    exp_t e;
    vin[0] = 128'h00010203_10111213_20212223_30313233;
    vout[0] = 128'h00112233_10213203_20310213_30011223;
    vin[1] = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    vout[1] = 128'h00050A0F_04090E03_080D0207_0C01060B;
    vin[2] = 128'h0;
    vout[2] = 128'h0;
    vin[3] = {128{1'b1}};
    vout[3] = {128{1'b1}};
    for (int k = 0; k < 4; k++) begin
      apply_exp(1'b1, vin[k], 1'b0, vout[k]);
      e = exp_q.pop_front();
      checks++;
      txn++;
      $display("txn %0d vector%0d in=%h out=%h v=%b", txn, k, vin[k], o_block, o_valid);
      if (o_valid !== e.v || o_block !== e.b) begin
        errors++;
        $display("FAIL vector%0d: got v=%b blk=%h, want v=%b blk=%h",
                 k, o_valid, o_block, e.v, e.b);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    // Load a known value, then idle. o_valid drops and o_block holds.
    apply(1'b1, 128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b0);
    void'(exp_q.pop_front());
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, rand128(), 1'b0);
      e = exp_q.pop_front();
      checks++;
      txn++;
      $display("txn %0d hold%0d out=%h v=%b", txn, k, o_block, o_valid);
      if (o_valid !== 1'b0 || o_block !== e.b) begin
        errors++;
        $display("FAIL hold%0d: got v=%b blk=%h, want v=0 blk=%h",
                 k, o_valid, o_block, e.b);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic v;
    for (int k = 0; k < 40; k++) begin
      // Random valid pattern, with long all-valid bursts at the start.
      v = (k < 16) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      apply(v, rand128(), 1'b0);
      e = exp_q.pop_front();
      checks++;
      txn++;
      $display("txn %0d stream v_in=%b out=%h v=%b", txn, v, o_block, o_valid);
      if (o_valid !== e.v || o_block !== e.b) begin
        errors++;
        $display("FAIL stream%0d: got v=%b blk=%h, want v=%b blk=%h",
                 k, o_valid, o_block, e.v, e.b);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    apply(1'b1, rand128(), 1'b0);
    void'(exp_q.pop_front());
    // Reset on the same edge as a valid input: that input is discarded.
    rst = 1'b1;
    apply(1'b1, rand128(), 1'b0);
    void'(exp_q.pop_front());
    rst = 1'b0;
    hold_model = 128'h0;
    checks++;
    if (o_valid !== 1'b0 || o_block !== 128'h0) begin
      errors++;
      $display("FAIL midreset: got v=%b blk=%h, want v=0 blk=0", o_valid, o_block);
    end
    // The first valid input after reset is processed normally.
    apply(1'b1, 128'h00010203_10111213_20212223_30313233, 1'b0);
    e = exp_q.pop_front();
    checks++;
    txn++;
    $display("txn %0d after_reset out=%h v=%b", txn, o_block, o_valid);
    if (o_valid !== 1'b1 || o_block !== 128'h00112233_10213203_20310213_30011223) begin
      errors++;
      $display("FAIL after_reset: got v=%b blk=%h, want v=1 blk=%h",
               o_valid, o_block, e.b);
    end
  endtask

`ifdef SHIFTROWS_INV_EN
  task automatic test_inverse();
    exp_t e;
    logic [127:0] r;
    logic [127:0] mid;
    apply_exp(1'b1, 128'h00112233_10213203_20310213_30011223, 1'b1,
              128'h00010203_10111213_20212223_30313233);
    e = exp_q.pop_front();
    checks++;
    txn++;
    $display("txn %0d inverse out=%h v=%b", txn, o_block, o_valid);
    if (o_valid !== e.v || o_block !== e.b) begin
      errors++;
      $display("FAIL inverse: got v=%b blk=%h, want v=%b blk=%h",
               o_valid, o_block, e.v, e.b);
    end
    for (int k = 0; k < 8; k++) begin
      r = rand128();
      apply(1'b1, r, 1'b0);
      void'(exp_q.pop_front());
      mid = o_block;
      apply(1'b1, mid, 1'b1);
      void'(exp_q.pop_front());
      checks++;
      txn++;
      $display("txn %0d roundtrip in=%h out=%h", txn, r, o_block);
      if (o_valid !== 1'b1 || o_block !== r) begin
        errors++;
        $display("FAIL roundtrip%0d: got v=%b blk=%h, want v=1 blk=%h",
                 k, o_valid, o_block, r);
      end
    end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    txn        = 0;
    hold_model = 128'h0;
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_block    = 128'h0;
    i_inv      = 1'b0;
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
`ifdef SHIFTROWS_INV_EN
    test_inverse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
